ysyx_23060208_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_23060208_ifu_fetch

Overview:
Instruction fetch unit. It is the producer side of the IFU->IDU valid/allowin handshake and drives the 64-bit {pc, inst} bus consumed by the decode stage. It owns the PC, issues one outstanding request at a time to a variable-latency instruction memory (req/ready, resp/valid), and applies redirects from EXU (jal/jalr, taken branches, ecall/mret nextpc). Wrong-path fetches are squashed.

Parameters:
DATA_WIDTH, 32, width of pc, address and instruction.
RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  reset; synchronous, active-high.
ifu_to_idu_bus  out  2*DATA_WIDTH  {pc, inst}; pc in the upper half.
ifu_to_idu_valid  out  1  bus holds a valid instruction for IDU.
idu_allowin  in  1  IDU accepts this cycle; a transfer is ifu_to_idu_valid && idu_allowin.
redirect_valid  in  1  single-cycle pulse from EXU; the next fetch PC is redirect_pc.
redirect_pc  in  DATA_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
imem_req_valid  out  1  fetch request.
imem_req_addr  out  DATA_WIDTH  fetch address, word aligned.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_resp_valid  in  1  response data is valid; one response per accepted request, arriving at least 1 cycle later.
imem_resp_data  in  DATA_WIDTH  instruction word.

Behaviour:
- The clock port is clk and the reset port is rst. There is one clock, and reset is synchronous and active-high.
- Reset:
  - pc=RESET_PC, state=REQ, drop=0, bus register=0, hold_valid=0.
  - Outputs after reset: ifu_to_idu_valid=0, ifu_to_idu_bus=0, imem_req_valid=1 (the REQ state drives it), imem_req_addr=RESET_PC.
  - Reset mid-operation abandons any outstanding request.
- States: REQ, WAIT, HOLD.
- REQ:
  - Drive imem_req_valid=1 and imem_req_addr=pc.
  - imem_resp_valid is ignored in this state, so stale responses after reset are dropped.
  - If imem_req_ready: go to WAIT. If redirect_valid is also high that cycle, set drop=1 and pc<=redirect_pc.
  - If not imem_req_ready and redirect_valid: pc<=redirect_pc, stay in REQ. The address changes on the next cycle; this is legal because the old request was never accepted.
- WAIT:
  - imem_req_valid=0.
  - redirect_valid: pc<=redirect_pc and drop<=1. If several redirects arrive, the last one wins.
  - On imem_resp_valid with drop=1 (or redirect_valid the same cycle): discard the data, clear drop, go to REQ.
  - On imem_resp_valid with drop=0 and no redirect: bus register<={pc, imem_resp_data}, hold_valid<=1, go to HOLD.
- HOLD:
  - imem_req_valid=0.
  - ifu_to_idu_valid = hold_valid && !redirect_valid. This is combinational masking: an instruction in HOLD is younger than the redirecting one, so it must not transfer.
  - redirect_valid (regardless of idu_allowin): hold_valid<=0, pc<=redirect_pc, go to REQ.
  - Transfer (valid && allowin, no redirect): hold_valid<=0, pc<=pc+4, go to REQ.
  - Otherwise stall. The bus and valid stay stable, and no new request is issued.
- PC arithmetic: pc+4 is modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC wraps to 0.
- Best-case latency: request accepted in cycle 0, response in cycle 1, ifu_to_idu_valid=1 in cycle 2, next request in cycle 3. There is at most one outstanding request.
- ifu_to_idu_bus is driven only from the bus register. It changes only on a WAIT->HOLD capture.
- Invariant: imem_req_valid is 1 iff the state is REQ. ifu_to_idu_valid is never 1 outside HOLD.

Test Plan:
1. Reset release with ready=1, response latency 1, mem[0x80000000]=0x00100093 -> req addr 0x80000000 at cycle 0; cycle 2 valid=1, bus={0x80000000,0x00100093}; allowin=1 -> cycle 3 req addr 0x80000004.
2. Backpressure: hold idu_allowin=0 for 5 cycles in HOLD -> valid stays 1, bus is unchanged, imem_req_valid stays 0; allowin=1 -> next req at pc+4.
3. Memory stall: imem_req_ready=0 for 4 cycles -> req_valid=1 and addr constant 0x80000000 throughout; ready=1 -> response flows normally.
4. Redirect in WAIT to 0x80000100, response 3 cycles later -> that response never raises ifu_to_idu_valid; next req addr is 0x80000100, and its instruction appears with pc 0x80000100.
5. Redirect in HOLD coinciding with idu_allowin=1, target 0x80000200 -> ifu_to_idu_valid=0 in that cycle; next req addr is 0x80000200.
6. Reset asserted in WAIT, with a stale response arriving 1 cycle after release -> stale data is ignored; req addr is 0x80000000 and the first valid bus is {0x80000000, fresh data}. Also: pc 0xFFFFFFFC with a transfer -> next req addr 0x00000000.

Source files
------------

// File: rtl/ysyx_23060208_ifu_fetch.sv
// ysyx_23060208_ifu_fetch: instruction fetch unit, one outstanding imem request, squashes wrong-path fetches on EXU redirect.
module ysyx_23060208_ifu_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [2*DATA_WIDTH-1:0] ifu_to_idu_bus,
  output logic                    ifu_to_idu_valid,
  input  logic                    idu_allowin,
  input  logic                    redirect_valid,
  input  logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    imem_req_valid,
  output logic [DATA_WIDTH-1:0]   imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t r_state, w_state_n;
  logic [DATA_WIDTH-1:0]   r_pc, w_pc_n, w_redir_pc;
  logic [2*DATA_WIDTH-1:0] r_bus;
  logic                    r_drop, w_drop_n, r_hold_valid, w_hold_n, w_cap, w_fire;
  assign w_redir_pc       = redirect_pc & ~DATA_WIDTH'(3);
  assign imem_req_valid   = r_state == S_REQ;
  assign imem_req_addr    = r_pc;
  assign ifu_to_idu_bus   = r_bus;
  // a redirect means the held instruction is younger than the redirecting one
  assign ifu_to_idu_valid = (r_state == S_HOLD) && r_hold_valid && !redirect_valid;
  assign w_fire           = ifu_to_idu_valid && idu_allowin;
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_drop_n  = r_drop;
    w_hold_n  = r_hold_valid;
    w_cap     = 1'b0;
    case (r_state)
      S_REQ: begin
        w_pc_n = redirect_valid ? w_redir_pc : r_pc;
        if (imem_req_ready) begin
          w_state_n = S_WAIT;
          w_drop_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_n   = w_redir_pc;
          w_drop_n = 1'b1;
        end
        if (imem_resp_valid) begin
          w_state_n = (r_drop || redirect_valid) ? S_REQ : S_HOLD;
          w_drop_n  = 1'b0;
          w_cap     = !(r_drop || redirect_valid);
          w_hold_n  = !(r_drop || redirect_valid);
        end
      end
      S_HOLD: begin
        if (redirect_valid || w_fire) begin
          w_state_n = S_REQ;
          w_hold_n  = 1'b0;
          w_pc_n    = redirect_valid ? w_redir_pc : r_pc + DATA_WIDTH'(4);
        end
      end
      default: w_state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_hold_valid <= 1'b0;
      r_bus        <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_drop       <= w_drop_n;
      r_hold_valid <= w_hold_n;
      if (w_cap) r_bus <= {r_pc, imem_resp_data};
    end
  end
endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// tb_ysyx_23060208_ifu_fetch: directed bench with a latency-programmable imem model and a transfer scoreboard.
module tb_ysyx_23060208_ifu_fetch;
  logic        clk = 0, rst = 1;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid, idu_allowin = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        imem_req_valid, imem_req_ready = 1, imem_resp_valid = 0;
  logic [31:0] imem_req_addr, imem_resp_data = 0;
  int          checks = 0, errors = 0, lat = 1, cnt = 0;
  logic        pend = 0, acc_n = 0;
  logic [31:0] paddr = 0, addr_n = 0;
  logic [63:0] exp_q[$];

  ysyx_23060208_ifu_fetch dut (
    .clk(clk), .rst(rst),
    .ifu_to_idu_bus(ifu_to_idu_bus), .ifu_to_idu_valid(ifu_to_idu_valid), .idu_allowin(idu_allowin),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0093 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // memory model: one pending request, response lat cycles after acceptance; survives reset so stale data can appear
  always @(negedge clk) begin
    acc_n  = !rst && imem_req_valid && imem_req_ready;
    addr_n = imem_req_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_resp_valid = 0;
    if (acc_n) begin
      pend  = 1;
      cnt   = lat;
      paddr = addr_n;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_resp_valid = 1;
        imem_resp_data  = mem_f(paddr);
        pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifu_to_idu_valid && idu_allowin) begin
      if (exp_q.size() == 0) chk("xfer_unexpected", {32'h0, ifu_to_idu_bus[63:32]}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("xfer", ifu_to_idu_bus, exp_q.pop_front());
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(ifu_to_idu_valid), 64'd0);
    chk("rst_bus", ifu_to_idu_bus, 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rst_req_addr", 64'(imem_req_addr), 64'h8000_0000);
    rst = 0;
    idu_allowin = 1;
    exp_q.push_back({32'h8000_0000, 32'h0010_0093});
    tick();
    chk("t1_wait_req", 64'(imem_req_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(ifu_to_idu_valid), 64'd1);
    chk("t1_bus", ifu_to_idu_bus, {32'h8000_0000, 32'h0010_0093});
    tick();
    chk("t1_next_addr", 64'(imem_req_addr), 64'h8000_0004);
    idu_allowin = 0;
    exp_q.push_back({32'h8000_0004, mem_f(32'h8000_0004)});
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 64'(ifu_to_idu_valid), 64'd1);
      chk("t2_bus", ifu_to_idu_bus, {32'h8000_0004, mem_f(32'h8000_0004)});
      chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
      tick();
    end
    idu_allowin = 1;
    tick();
    chk("t2_next_addr", 64'(imem_req_addr), 64'h8000_0008);
    imem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_req_valid", 64'(imem_req_valid), 64'd1);
      chk("t3_req_addr", 64'(imem_req_addr), 64'h8000_0008);
      tick();
    end
    imem_req_ready = 1;
    exp_q.push_back({32'h8000_0008, mem_f(32'h8000_0008)});
    tick();
    tick();
    chk("t3_valid", 64'(ifu_to_idu_valid), 64'd1);
    tick();
    chk("t3_next_addr", 64'(imem_req_addr), 64'h8000_000C);
    lat = 3;
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h8000_0103;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t4_squash_valid", 64'(ifu_to_idu_valid), 64'd0);
      tick();
    end
    chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t4_req_addr", 64'(imem_req_addr), 64'h8000_0100);
    lat = 1;
    exp_q.push_back({32'h8000_0100, mem_f(32'h8000_0100)});
    tick();
    tick();
    chk("t4_valid", 64'(ifu_to_idu_valid), 64'd1);
    tick();
    chk("t4_next_addr", 64'(imem_req_addr), 64'h8000_0104);
    tick();
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h8000_0200;
    #1;
    chk("t5_masked_valid", 64'(ifu_to_idu_valid), 64'd0);
    tick();
    redirect_valid = 0;
    chk("t5_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t5_req_addr", 64'(imem_req_addr), 64'h8000_0200);
    exp_q.push_back({32'h8000_0200, mem_f(32'h8000_0200)});
    tick();
    tick();
    chk("t5_valid", 64'(ifu_to_idu_valid), 64'd1);
    tick();
    chk("t5_next_addr", 64'(imem_req_addr), 64'h8000_0204);
    lat = 3;
    tick();
    rst = 1;
    imem_req_ready = 0;
    tick();
    chk("t6_rst_addr", 64'(imem_req_addr), 64'h8000_0000);
    chk("t6_rst_bus", ifu_to_idu_bus, 64'd0);
    chk("t6_rst_valid", 64'(ifu_to_idu_valid), 64'd0);
    rst = 0;
    tick();
    chk("t6_stale_seen", 64'(imem_resp_valid), 64'd1);
    chk("t6_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6_req_addr", 64'(imem_req_addr), 64'h8000_0000);
    imem_req_ready = 1;
    lat = 1;
    exp_q.push_back({32'h8000_0000, 32'h0010_0093});
    tick();
    chk("t6_wait_valid", 64'(ifu_to_idu_valid), 64'd0);
    tick();
    chk("t6_valid", 64'(ifu_to_idu_valid), 64'd1);
    chk("t6_bus", ifu_to_idu_bus, {32'h8000_0000, 32'h0010_0093});
    tick();
    chk("t6_next_addr", 64'(imem_req_addr), 64'h8000_0004);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    chk("wrap_drop_valid", 64'(ifu_to_idu_valid), 64'd0);
    tick();
    chk("wrap_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    exp_q.push_back({32'hFFFF_FFFC, mem_f(32'hFFFF_FFFC)});
    tick();
    tick();
    chk("wrap_valid", 64'(ifu_to_idu_valid), 64'd1);
    tick();
    chk("wrap_next_addr", 64'(imem_req_addr), 64'h0000_0000);
    tick();
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
